// File: rtl/sound_mixer.sv
// sound_mixer: multi-channel square-wave tone generator with a 1-bit mixer.
//
// Each channel plays a square wave whose half-period is `period` tone ticks.
// It plays for `duration` duration units, or forever when duration is 0.
// A shared free-running prescaler chain supplies two strobes:
//   tone_tick every PRESCALE clocks, and
//   dur_tick every DUR_PRESCALE tone ticks.
// The channel outputs are combined either by OR (MIX_MODE=0) or by a
// first-order sigma-delta accumulator (MIX_MODE=1).
//
// Parameters:
//   NUM_CHANNELS  number of channels (1..8)
//   PERIOD_WIDTH  width of the half-period value
//   DUR_WIDTH     width of the duration value
//   PRESCALE      clk cycles per tone tick
//   DUR_PRESCALE  tone ticks per duration unit
//   MIX_MODE      0 = OR mixer, 1 = sigma-delta mixer
//   SEL_WIDTH     width of ch_sel; may be widened beyond the channel count
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        global run enable; 0 freezes all state and mutes buzzer
//   ch_sel    channel targeted by latch
//   period    half-period in tone ticks (0 = silence)
//   duration  play length in duration units (0 = until relatched)
//   latch     one-cycle write strobe
//   busy      per-channel playing flag
//   buzzer    registered 1-bit audio output
module sound_mixer #(
  parameter int NUM_CHANNELS = 4,
  parameter int PERIOD_WIDTH = 16,
  parameter int DUR_WIDTH    = 16,
  parameter int PRESCALE     = 50,
  parameter int DUR_PRESCALE = 1000,
  parameter int MIX_MODE     = 1,
  parameter int SEL_WIDTH    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [SEL_WIDTH-1:0]    ch_sel,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [DUR_WIDTH-1:0]    duration,
  input  logic                    latch,
  output logic [NUM_CHANNELS-1:0] busy,
  output logic                    buzzer
);

  localparam int TICK_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DCNT_W = (DUR_PRESCALE > 1) ? $clog2(DUR_PRESCALE) : 1;
  localparam int CNT_W  = $clog2(NUM_CHANNELS + 1);
  localparam int ACC_W  = $clog2(NUM_CHANNELS) + 1;

  typedef enum logic {S_IDLE, S_PLAY} ch_state_t;

  logic [TICK_W-1:0]       tick_cnt;
  logic [DCNT_W-1:0]       dur_cnt;
  logic                    tone_tick;
  logic                    dur_tick;
  logic                    latch_ok;
  logic [NUM_CHANNELS-1:0] sq_on;
  logic [CNT_W-1:0]        s;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        t;

  assign tone_tick = en && (tick_cnt == TICK_W'(PRESCALE - 1));
  assign dur_tick  = tone_tick && (dur_cnt == DCNT_W'(DUR_PRESCALE - 1));
  // Out-of-range channel selects are dropped here, so no channel sees them.
  assign latch_ok  = en && latch &&
                     ({1'b0, ch_sel} < (SEL_WIDTH + 1)'(NUM_CHANNELS));

  // Free-running prescaler chain; latch never resets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      dur_cnt  <= '0;
    end else if (tone_tick) begin
      tick_cnt <= '0;
      dur_cnt  <= (dur_cnt == DCNT_W'(DUR_PRESCALE - 1)) ? '0 : dur_cnt + 1'b1;
    end else if (en) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    ch_state_t               state_q;
    ch_state_t               state_d;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [PERIOD_WIDTH-1:0] phase;
    logic [DUR_WIDTH-1:0]    dur_rem;
    logic                    sq;
    logic                    hit;
    logic                    expire;
    logic                    busy_c;

    assign hit    = latch_ok && (ch_sel == SEL_WIDTH'(gi));
    assign expire = dur_tick && (dur_rem == DUR_WIDTH'(1));

    always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
    end

    // A latch overrides a coincident expiry.
    always_comb begin
      state_d = state_q;
      if (hit)
        state_d = (period != '0) ? S_PLAY : S_IDLE;
      else if (state_q == S_PLAY && expire)
        state_d = S_IDLE;
    end

    always_comb begin
      busy_c = (state_q == S_PLAY);
    end

    // Latch beats expiry, and expiry beats toggle.
    // So a relatch never emits a stray edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        period_q <= '0;
        dur_rem  <= '0;
        phase    <= '0;
        sq       <= 1'b0;
      end else if (hit) begin
        period_q <= period;
        dur_rem  <= duration;
        phase    <= '0;
        sq       <= 1'b0;
      end else if (state_q == S_PLAY) begin
        if (expire) begin
          dur_rem <= dur_rem - 1'b1;
          phase   <= '0;
          sq      <= 1'b0;
        end else begin
          if (dur_tick && dur_rem != '0)
            dur_rem <= dur_rem - 1'b1;
          if (tone_tick) begin
            if (phase == period_q - 1'b1) begin
              phase <= '0;
              sq    <= ~sq;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
      end
    end

    assign busy[gi]  = busy_c;
    assign sq_on[gi] = busy_c && sq;
  end

  always_comb begin
    s = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++)
      s = s + CNT_W'(sq_on[i]);
  end

  assign t = acc + ACC_W'(s);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      buzzer <= 1'b0;
    end else if (!en) begin
      buzzer <= 1'b0;
    end else if (MIX_MODE == 0) begin
      buzzer <= (s != '0);
    end else if (t >= ACC_W'(NUM_CHANNELS)) begin
      acc    <= t - ACC_W'(NUM_CHANNELS);
      buzzer <= 1'b1;
    end else begin
      acc    <= t;
      buzzer <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sound_mixer.sv
// tb_sound_mixer: drives an OR-mixer and a sigma-delta instance of
// sound_mixer with identical stimulus.
// Both instances use 4 channels, PRESCALE=2, DUR_PRESCALE=4 and a
// 3-bit ch_sel.
// Outputs are compared every cycle against a behavioural channel model.
// Directed scenarios are followed by a randomized run.
module tb_sound_mixer;

  localparam int NCH  = 4;
  localparam int PRE  = 2;
  localparam int DPRE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        latch;
  logic [2:0]  ch_sel;
  logic [15:0] period;
  logic [15:0] duration;
  logic [3:0]  busy_or;
  logic [3:0]  busy_sd;
  logic        buzzer_or;
  logic        buzzer_sd;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int m_tick;
  int m_dcnt;
  int m_acc;
  int m_per   [NCH];
  int m_rem   [NCH];
  int m_phase [NCH];
  bit m_sq    [NCH];
  bit m_busy  [NCH];
  bit m_buz_or;
  bit m_buz_sd;

  always #5 clk = ~clk;

  sound_mixer #(
    .NUM_CHANNELS(NCH), .PERIOD_WIDTH(16), .DUR_WIDTH(16),
    .PRESCALE(PRE), .DUR_PRESCALE(DPRE), .MIX_MODE(0), .SEL_WIDTH(3)
  ) u_or (
    .clk(clk), .rst(rst), .en(en), .ch_sel(ch_sel), .period(period),
    .duration(duration), .latch(latch), .busy(busy_or), .buzzer(buzzer_or)
  );

  sound_mixer #(
    .NUM_CHANNELS(NCH), .PERIOD_WIDTH(16), .DUR_WIDTH(16),
    .PRESCALE(PRE), .DUR_PRESCALE(DPRE), .MIX_MODE(1), .SEL_WIDTH(3)
  ) u_sd (
    .clk(clk), .rst(rst), .en(en), .ch_sel(ch_sel), .period(period),
    .duration(duration), .latch(latch), .busy(busy_sd), .buzzer(buzzer_sd)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [3:0] m_busy_vec();
    logic [3:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int  s;
    bit  tone;
    bit  dtick;
    if (rst) begin
      m_tick = 0; m_dcnt = 0; m_acc = 0; m_buz_or = 0; m_buz_sd = 0;
      for (int i = 0; i < NCH; i++) begin
        m_per[i] = 0; m_rem[i] = 0; m_phase[i] = 0; m_sq[i] = 0; m_busy[i] = 0;
      end
      return;
    end
    if (!en) begin
      m_buz_or = 0;
      m_buz_sd = 0;
      return;
    end
    s = 0;
    for (int i = 0; i < NCH; i++) if (m_busy[i] && m_sq[i]) s++;
    m_buz_or = (s != 0);
    if (m_acc + s >= NCH) begin
      m_acc = m_acc + s - NCH; m_buz_sd = 1;
    end else begin
      m_acc = m_acc + s; m_buz_sd = 0;
    end
    tone  = (m_tick == PRE - 1);
    m_tick = (m_tick + 1) % PRE;
    dtick = tone && (m_dcnt == DPRE - 1);
    if (tone) m_dcnt = (m_dcnt + 1) % DPRE;
    for (int i = 0; i < NCH; i++) begin
      if (latch && int'(ch_sel) == i) begin
        m_per[i] = int'(period); m_rem[i] = int'(duration);
        m_phase[i] = 0; m_sq[i] = 0; m_busy[i] = (period != 0);
      end else if (m_busy[i]) begin
        if (dtick && m_rem[i] == 1) begin
          m_busy[i] = 0; m_sq[i] = 0; m_phase[i] = 0; m_rem[i] = 0;
        end else begin
          if (dtick && m_rem[i] != 0) m_rem[i]--;
          if (tone) begin
            if (m_phase[i] == m_per[i] - 1) begin
              m_phase[i] = 0; m_sq[i] = ~m_sq[i];
            end else begin
              m_phase[i]++;
            end
          end
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("busy_or",   32'(busy_or),   32'(m_busy_vec()));
    check("busy_sd",   32'(busy_sd),   32'(m_busy_vec()));
    check("buzzer_or", 32'(buzzer_or), 32'(m_buz_or));
    check("buzzer_sd", 32'(buzzer_sd), 32'(m_buz_sd));
    check("acc",       32'(u_sd.acc),  32'(m_acc));
  endtask

  task automatic do_latch(input int sel, input int per, input int dur);
    latch = 1'b1; ch_sel = 3'(sel); period = 16'(per); duration = 16'(dur);
    step();
    latch = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin : stim
    int         k;
    int         highs;
    bit         found;
    logic [3:0] saved;
    logic [2:0] acc_saved;

    rst = 1'b1; en = 1'b0; latch = 1'b0; ch_sel = '0; period = '0; duration = '0;
    repeat (2) begin
      step();
      check("rst_busy", 32'(busy_or), 32'h0);
      check("rst_buzz", 32'(buzzer_sd), 32'h0);
    end
    rst = 1'b0; en = 1'b1;
    repeat (3) step();

    // OR mixer: channel 0, 6-clk half-period, unlimited duration.
    do_latch(0, 3, 0);
    check("busy0_next", 32'(busy_or[0]), 32'h1);
    k = 0;
    found = 0;
    while (!found && k < 20) begin
      step();
      k++;
      if (buzzer_or) found = 1;
    end
    check("first_rise", 32'(found && k >= 5 && k <= 7), 32'h1);
    repeat (20) step();
    highs = 0;
    repeat (240) begin
      step();
      if (buzzer_or) highs++;
    end
    check("or_duty", 32'(highs), 32'd120);
    repeat (1000 - 260 - k) step();
    check("busy0_hold", 32'(busy_or[0]), 32'h1);

    // Duration expiry, then a relatch one cycle before expiry.
    do_latch(1, 1, 2);
    repeat (20) step();
    check("ch1_expired", 32'(busy_or[1]), 32'h0);
    do_latch(1, 1, 2);
    k = 0;
    while (!(m_rem[1] == 1 && m_dcnt == DPRE - 1 && m_tick == 0) && k < 100) begin
      step();
      k++;
    end
    check("relatch_wait", 32'(k < 100), 32'h1);
    do_latch(1, 1, 3);
    repeat (16) step();
    check("relatch_hold", 32'(busy_or[1]), 32'h1);
    step();
    check("relatch_exp", 32'(busy_or[1]), 32'h0);

    // Reset after activity, then sigma-delta density with two channels.
    rst = 1'b1;
    repeat (2) begin
      step();
      check("rst2_busy", 32'(busy_sd), 32'h0);
      check("rst2_acc", 32'(u_sd.acc), 32'h0);
    end
    rst = 1'b0;
    do_latch(0, 1, 0);
    do_latch(1, 1, 0);
    repeat (8) step();
    highs = 0;
    repeat (400) begin
      step();
      if (buzzer_sd) highs++;
    end
    check("sd_density", 32'(highs >= 98 && highs <= 102), 32'h1);

    // Out-of-range select is ignored; period 0 silences a channel.
    saved = busy_sd;
    do_latch(5, 3, 1);
    check("sel5_ignored", 32'(busy_sd), 32'(saved));
    do_latch(2, 2, 0);
    repeat (5) step();
    do_latch(2, 0, 0);
    check("ch2_silenced", 32'(busy_sd[2]), 32'h0);

    // Freeze with en=0, then resume.
    repeat (3) step();
    acc_saved = u_sd.acc;
    saved = busy_sd;
    en = 1'b0;
    repeat (20) begin
      step();
      check("frz_buzz", 32'(buzzer_sd | buzzer_or), 32'h0);
      check("frz_busy", 32'(busy_sd), 32'(saved));
    end
    check("frz_acc", 32'(u_sd.acc), 32'(acc_saved));
    en = 1'b1;
    repeat (40) step();

    // Reset while disabled.
    en = 1'b0; rst = 1'b1;
    step();
    check("rst_dis_busy", 32'(busy_or), 32'h0);
    check("rst_dis_acc", 32'(u_sd.acc), 32'h0);
    rst = 1'b0; en = 1'b1;
    repeat (30) step();
    check("silent_after_rst", 32'(busy_sd), 32'h0);

    // Randomized traffic.
    repeat (3000) begin
      rst      = ($urandom_range(0, 199) == 0);
      en       = ($urandom_range(0, 19) != 0);
      latch    = ($urandom_range(0, 5) == 0);
      ch_sel   = 3'($urandom_range(0, 7));
      period   = 16'($urandom_range(0, 4));
      duration = 16'($urandom_range(0, 3));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
